// File: rtl/audio_mix_pkg.sv
// Shared types and helpers for the audio mix scheduler.
// Holds default widths, the sample type, the FSM state encoding and the
// saturation helper used by the SAT stage.
package audio_mix_pkg;

  localparam int DEF_SAMPLE_BITS = 16;
  localparam int DEF_VOLUME_BITS = 8;

  typedef logic signed [DEF_SAMPLE_BITS-1:0] sample_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_MAC   = 3'd2,
    ST_SAT   = 3'd3,
    ST_WRITE = 3'd4
  } mix_state_e;

  // Clamp a wide signed value into a signed range of 'bits' bits.
  // The result is returned sign-extended; callers keep the low 'bits' bits.
  function automatic logic signed [63:0] sat_to_sample(
    input  logic signed [63:0] value,
    input  int unsigned        bits,
    output logic               clipped
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bits - 1));
    clipped = 1'b0;
    sat_to_sample = value;
    if (value > hi) begin
      sat_to_sample = hi;
      clipped = 1'b1;
    end else if (value < lo) begin
      sat_to_sample = lo;
      clipped = 1'b1;
    end
  endfunction

endpackage

// File: rtl/audio_mix_scheduler_if.sv
// Source/ring-buffer bus of the audio mix scheduler.
// master: the side that supplies sources and consumes ring-buffer writes.
// slave : the scheduler itself.
interface audio_mix_scheduler_if #(
  parameter int NUM_SRC     = 4,
  parameter int SAMPLE_BITS = 16,
  parameter int VOLUME_BITS = 8,
  parameter int BUF_LEN     = 256
);
  localparam int AW = $clog2(BUF_LEN);

  logic                           refresh;
  logic [NUM_SRC*SAMPLE_BITS-1:0] src_sample;
  logic [NUM_SRC-1:0]             src_valid;
  logic [NUM_SRC*VOLUME_BITS-1:0] src_vol;
  logic [NUM_SRC-1:0]             src_en;
  logic [AW-1:0]                  play_index;
  logic                           wr_en;
  logic [AW-1:0]                  wr_addr;
  logic [SAMPLE_BITS-1:0]         wr_data;

  modport master (
    output refresh, src_sample, src_valid, src_vol, src_en, play_index,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  refresh, src_sample, src_valid, src_vol, src_en, play_index,
    output wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/lrclk_edge_sync.sv
// Brings the I2S frame clock into the clk domain and flags its falling edge.
// All three flops reset high so a line idling high never produces a tick.
module lrclk_edge_sync (
  input  logic clk,
  input  logic rstn,
  input  logic lrclk,
  output logic frame_tick
);

  logic sync1, sync2, hist;

  // Two-flop synchroniser followed by one history flop for edge detection.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbour.
    if (!rstn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 1'b1;
    end else begin
      sync1 <= lrclk;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign frame_tick = hist & ~sync2;

endmodule

// File: rtl/audio_mix_scheduler.sv
// Frame-synchronous mixer: snapshots all sources on each lrclk falling edge,
// runs one shared multiply-accumulate per source, then writes one mixed
// sample into the playback ring buffer LAG entries behind the player.
// Build option AUDIO_MIX_SATURATE_EN: clamp the mix and count clips;
// without it the mix wraps and clip_count stays 0.
module audio_mix_scheduler
  import audio_mix_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int VOLUME_BITS = DEF_VOLUME_BITS,
  parameter int BUF_LEN     = 256,
  parameter int LAG         = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        lrclk,
  audio_mix_scheduler_if.slave        bus,
  output logic                        busy,
  output logic                        missed_frame,
  output logic [15:0]                 clip_count
);

  localparam int AW     = $clog2(BUF_LEN);
  localparam int PROD_W = SAMPLE_BITS + VOLUME_BITS + 1;
  localparam int ACC_W  = PROD_W + $clog2(NUM_SRC);
  localparam int CNT_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [CNT_W-1:0] LAST_SRC = CNT_W'(NUM_SRC - 1);
  localparam logic [AW-1:0]    LAG_A    = AW'(LAG);

  logic                          frame_tick;
  mix_state_e                    state;
  logic [CNT_W-1:0]              src_idx;
  logic signed [ACC_W-1:0]       acc;
  logic [AW-1:0]                 wr_addr_q;
  logic [SAMPLE_BITS-1:0]        wr_data_q;
  logic                          missed_q;

  logic signed [SAMPLE_BITS-1:0] smp_q [NUM_SRC];
  logic [VOLUME_BITS-1:0]        vol_q [NUM_SRC];
  logic [NUM_SRC-1:0]            act_q;
  logic [AW-1:0]                 pidx_q;
  logic                          refresh_q;

  logic signed [PROD_W-1:0]      smp_x, vol_x, prod;
  logic signed [ACC_W-1:0]       term;
  logic [SAMPLE_BITS-1:0]        mix;

  lrclk_edge_sync u_sync (
    .clk        (clk),
    .rstn       (rstn),
    .lrclk      (lrclk),
    .frame_tick (frame_tick)
  );

  // Frame snapshot taken during LATCH; later input changes cannot reach the mix.
  always_ff @(posedge clk) begin
    // NOTE: snapshot registers carry no reset; they are always reloaded in LATCH before MAC reads them.
    if (state == ST_LATCH) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        smp_q[i] <= bus.src_sample[i*SAMPLE_BITS +: SAMPLE_BITS];
        vol_q[i] <= bus.src_vol[i*VOLUME_BITS +: VOLUME_BITS];
      end
      act_q     <= bus.src_en & bus.src_valid;
      pidx_q    <= bus.play_index;
      refresh_q <= bus.refresh;
    end
  end

  // Scaled contribution of the source selected by src_idx (vol is unsigned).
  always_comb begin
    // NOTE: every comb output is assigned on all paths so no latch is inferred.
    smp_x = PROD_W'(smp_q[src_idx]);
    vol_x = PROD_W'({1'b0, vol_q[src_idx]});
    prod  = smp_x * vol_x;
    term  = act_q[src_idx] ? ACC_W'(prod) : '0;
  end

`ifdef AUDIO_MIX_SATURATE_EN
  logic        clipped;
  logic [15:0] clip_q;

  // Drop the gain fraction and clamp to the sample range.
  always_comb begin
    clipped = 1'b0;
    mix     = SAMPLE_BITS'(sat_to_sample(64'(acc >>> VOLUME_BITS), SAMPLE_BITS, clipped));
  end

  // Saturating count of clamped output samples.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      clip_q <= '0;
    end else if (state == ST_SAT && clipped && clip_q != 16'hFFFF) begin
      clip_q <= clip_q + 16'd1;
    end
  end

  assign clip_count = clip_q;
`else
  // Drop the gain fraction and keep the low bits (two's-complement wrap).
  always_comb begin
    mix = SAMPLE_BITS'(acc >>> VOLUME_BITS);
  end

  assign clip_count = 16'h0;
`endif

  // Frame sequencer: IDLE -> LATCH -> MAC x NUM_SRC -> SAT -> WRITE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      src_idx   <= '0;
      acc       <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_tick) state <= ST_LATCH;
        end
        ST_LATCH: begin
          acc     <= '0;
          src_idx <= '0;
          state   <= ST_MAC;
        end
        ST_MAC: begin
          acc <= acc + term;
          if (src_idx == LAST_SRC) state <= ST_SAT;
          else src_idx <= src_idx + 1'b1;
        end
        ST_SAT: begin
          wr_data_q <= mix;
          wr_addr_q <= pidx_q - LAG_A;
          state     <= ST_WRITE;
        end
        ST_WRITE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Sticky flag for frame edges that arrive while a mix is still running.
  always_ff @(posedge clk) begin
    if (!rstn) missed_q <= 1'b0;
    else if (frame_tick && state != ST_IDLE) missed_q <= 1'b1;
  end

  assign busy         = (state != ST_IDLE);
  assign missed_frame = missed_q;
  assign bus.wr_en    = (state == ST_WRITE) && refresh_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;

endmodule

// File: tb/tb_audio_mix_scheduler.sv
// Self-checking bench for audio_mix_scheduler: directed frames for the
// documented corner cases, then randomized frames against an arithmetic
// reference model of the mix.
module tb_audio_mix_scheduler;
  import audio_mix_pkg::*;

  localparam int NUM_SRC = 4;
  localparam int SB      = 16;
  localparam int VB      = 8;
  localparam int BUF_LEN = 256;
  localparam int LAG     = 1;
  localparam int AW      = 8;

  logic        clk   = 1'b0;
  logic        rstn  = 1'b0;
  logic        lrclk = 1'b1;
  logic        busy;
  logic        missed_frame;
  logic [15:0] clip_count;

  audio_mix_scheduler_if #(
    .NUM_SRC(NUM_SRC), .SAMPLE_BITS(SB), .VOLUME_BITS(VB), .BUF_LEN(BUF_LEN)
  ) bus ();

  audio_mix_scheduler #(
    .NUM_SRC(NUM_SRC), .SAMPLE_BITS(SB), .VOLUME_BITS(VB), .BUF_LEN(BUF_LEN), .LAG(LAG)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .lrclk        (lrclk),
    .bus          (bus),
    .busy         (busy),
    .missed_frame (missed_frame),
    .clip_count   (clip_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: the frame's source settings plus sticky/counter expectations.
  sample_t     m_smp [NUM_SRC];
  logic [7:0]  m_vol [NUM_SRC];
  bit          m_en  [NUM_SRC];
  bit          m_val [NUM_SRC];
  bit          m_refresh;
  int unsigned m_pidx;
  int          m_clips;
  bit          m_missed;

  logic [AW-1:0] last_addr;
  logic [15:0]   last_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.src_sample[i*SB +: SB] = m_smp[i];
      bus.src_vol[i*VB +: VB]    = m_vol[i];
      bus.src_en[i]              = m_en[i];
      bus.src_valid[i]           = m_val[i];
    end
    bus.refresh    = m_refresh;
    bus.play_index = AW'(m_pidx);
  endtask

  // Mix = floor(sum(sample*vol over enabled valid sources) / 2^VB), then clamp or wrap.
  function automatic logic [15:0] model_mix(output bit clipped);
    longint acc;
    longint mix;
    acc = 0;
    for (int i = 0; i < NUM_SRC; i++)
      if (m_en[i] && m_val[i]) acc += longint'(m_smp[i]) * longint'(m_vol[i]);
    mix = acc >>> VB;
    clipped = 1'b0;
`ifdef AUDIO_MIX_SATURATE_EN
    if (mix > 32767) begin
      mix = 32767;
      clipped = 1'b1;
    end else if (mix < -32768) begin
      mix = -32768;
      clipped = 1'b1;
    end
`endif
    return mix[15:0];
  endfunction

  task automatic set_all_off();
    for (int i = 0; i < NUM_SRC; i++) begin
      m_smp[i] = '0;
      m_vol[i] = '0;
      m_en[i]  = 1'b0;
      m_val[i] = 1'b0;
    end
  endtask

  task automatic randomize_frame();
    for (int i = 0; i < NUM_SRC; i++) begin
      m_smp[i] = sample_t'($urandom);
      m_vol[i] = 8'($urandom_range(0, 255));
      m_en[i]  = ($urandom_range(0, 3) != 0);
      m_val[i] = ($urandom_range(0, 3) != 0);
    end
    m_pidx    = $urandom_range(0, BUF_LEN - 1);
    m_refresh = ($urandom_range(0, 5) != 0);
  endtask

  // One lrclk falling edge; the frame tick is expected two clocks later (cycle T),
  // busy over T+1..T+NUM_SRC+3 and the single write in T+NUM_SRC+3.
  // dbl adds a second falling edge two cycles after the tick; mutate flips all
  // source inputs in T+2.
  task automatic do_frame(input string tag, input bit dbl, input bit mutate);
    bit            clipped;
    logic [15:0]   exp_data;
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] got_addr;
    logic [15:0]   got_data;
    int            wr_cnt, wr_at, busy_err;
    logic          exp_busy;

    exp_data = model_mix(clipped);
    exp_addr = AW'(m_pidx - LAG);
    got_addr = '0;
    got_data = '0;
    wr_cnt   = 0;
    wr_at    = -1;
    busy_err = 0;

    @(negedge clk);
    drive_inputs();
    lrclk = 1'b0;
    for (int j = 1; j <= NUM_SRC + 10; j++) begin
      @(negedge clk);
      exp_busy = (j >= 3 && j <= NUM_SRC + 5);
      if (busy !== exp_busy) busy_err++;
      if (bus.wr_en === 1'b1) begin
        wr_cnt++;
        wr_at    = j;
        got_addr = bus.wr_addr;
        got_data = bus.wr_data;
      end
      if (dbl && j == 1) lrclk = 1'b1;
      if (dbl && j == 2) lrclk = 1'b0;
      if (mutate && j == 4) begin
        bus.src_sample = ~bus.src_sample;
        bus.src_vol    = ~bus.src_vol;
        bus.src_en     = ~bus.src_en;
        bus.src_valid  = ~bus.src_valid;
      end
    end
    lrclk = 1'b1;
    repeat (4) @(negedge clk);

    if (clipped && m_clips < 16'hFFFF) m_clips++;
    if (dbl) m_missed = 1'b1;

    check({tag, "_busy_window"}, busy_err, 0);
    check({tag, "_wr_count"}, wr_cnt, m_refresh ? 1 : 0);
    if (m_refresh) begin
      check({tag, "_wr_cycle"}, wr_at, NUM_SRC + 5);
      check({tag, "_wr_addr"}, got_addr, exp_addr);
      check({tag, "_wr_data"}, got_data, exp_data);
    end
    check({tag, "_clip_count"}, clip_count, m_clips);
    check({tag, "_missed"}, missed_frame, m_missed);
    last_addr = got_addr;
    last_data = got_data;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, bus.wr_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_missed"}, missed_frame, 0);
    check({tag, "_wr_addr"}, bus.wr_addr, 0);
    check({tag, "_wr_data"}, bus.wr_data, 0);
    check({tag, "_clip"}, clip_count, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wr_seen;

    // Reset with lrclk idle high so release produces no edge.
    set_all_off();
    m_refresh = 1'b0;
    m_pidx    = 0;
    m_clips   = 0;
    m_missed  = 1'b0;
    drive_inputs();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // One source, 1000 * 128/256 = 500, written at 10 - 1.
    set_all_off();
    m_smp[0] = 16'sd1000; m_vol[0] = 8'd128; m_en[0] = 1'b1; m_val[0] = 1'b1;
    m_pidx = 10; m_refresh = 1'b1;
    do_frame("single", 1'b0, 1'b0);
    check("single_addr_const", last_addr, 9);
    check("single_data_const", last_data, 500);

    // Write index wraps below zero.
    m_pidx = 0;
    do_frame("wrap", 1'b0, 1'b0);
    check("wrap_addr_const", last_addr, 255);

    // Full-scale overload on every source.
    for (int i = 0; i < NUM_SRC; i++) begin
      m_smp[i] = 16'sh7FFF; m_vol[i] = 8'd255; m_en[i] = 1'b1; m_val[i] = 1'b1;
    end
    m_pidx = 50;
    do_frame("overload", 1'b0, 1'b0);
`ifdef AUDIO_MIX_SATURATE_EN
    check("overload_data_const", last_data, 16'h7FFF);
    check("overload_clip_const", clip_count, 1);
`else
    check("overload_data_const", last_data, 16'hFDFC);
    check("overload_clip_const", clip_count, 0);
`endif

    // refresh low plus a second edge while busy.
    randomize_frame();
    m_refresh = 1'b0;
    do_frame("norefresh_dbl", 1'b1, 1'b0);

    // Invalid-but-enabled source is excluded; late input changes are ignored.
    set_all_off();
    m_smp[0] = 16'sd1000;   m_vol[0] = 8'd200; m_en[0] = 1'b1; m_val[0] = 1'b1;
    m_smp[1] = -16'sd20000; m_vol[1] = 8'd255; m_en[1] = 1'b1; m_val[1] = 1'b0;
    m_smp[2] = -16'sd300;   m_vol[2] = 8'd64;  m_en[2] = 1'b1; m_val[2] = 1'b1;
    m_pidx = 77; m_refresh = 1'b1;
    do_frame("invalid_mutate", 1'b0, 1'b1);
    check("invalid_data_const", last_data, 16'(781 - 75));

    // Reset in the middle of MAC aborts the frame.
    randomize_frame();
    m_refresh = 1'b1;
    @(negedge clk);
    drive_inputs();
    lrclk = 1'b0;
    repeat (4) @(negedge clk);
    rstn  = 1'b0;
    lrclk = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    m_clips  = 0;
    m_missed = 1'b0;
    wr_seen  = 0;
    for (int j = 0; j < NUM_SRC + 6; j++) begin
      @(negedge clk);
      if (j == 2) rstn = 1'b1;
      if (bus.wr_en !== 1'b0) wr_seen++;
    end
    check("midreset_no_write", wr_seen, 0);
    do_frame("after_reset", 1'b0, 1'b0);

    // Randomized frames against the reference model.
    for (int k = 0; k < 16; k++) begin
      randomize_frame();
      do_frame($sformatf("rand%0d", k), ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
